// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state type and default word width for the serializer
package piso_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: bit counter with sync clear, load-to-1, increment and clock enable
module piso_bit_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = !en ? cnt_q : clr ? '0 : load ? W'(1) : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first, with registered valid and done
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic             sout_d, sout_q, sout_valid_d, sout_valid_q, done_d, done_q;
  logic             cnt_clr, cnt_load, cnt_inc;
  logic [CW-1:0]    cnt;
  piso_bit_cnt #(.W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (cnt_clr),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    done_d       = done_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: if (start) begin
          state_d      = SHIFT;
          sout_d       = din[WIDTH-1];
          sout_valid_d = 1'b1;
          shreg_d      = {din[WIDTH-2:0], 1'b0};
          cnt_load     = 1'b1;
        end
        SHIFT: if (cnt == CW'(WIDTH)) begin
          state_d      = DONE;
          sout_d       = 1'b0;
          sout_valid_d = 1'b0;
          done_d       = 1'b1;
          cnt_clr      = 1'b1;
        end else begin
          sout_d  = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_inc = 1'b1;
        end
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
    end
  end
  assign ready      = (state_q == IDLE);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed checks of piso_tx at WIDTH=8 and WIDTH=2
module tb_piso_tx;
  logic       clk = 1'b0, reset = 1'b1, en = 1'b0, start = 1'b0, start2 = 1'b0;
  logic [7:0] din = '0;
  logic [1:0] din2 = '0;
  logic       ready, sout, sout_valid, done;
  logic       ready2, sout2, sout_valid2, done2;
  logic       seen;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  piso_tx #(.WIDTH(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .start      (start),
    .din        (din),
    .ready      (ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );
  piso_tx #(.WIDTH(2)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .start      (start2),
    .din        (din2),
    .ready      (ready2),
    .sout       (sout2),
    .sout_valid (sout_valid2),
    .done       (done2)
  );
  function automatic logic [3:0] obs8();
    return {ready, done, sout_valid, sout};
  endfunction
  function automatic logic [3:0] obs2();
    return {ready2, done2, sout_valid2, sout2};
  endfunction
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {rdy,done,vld,sout}=%b expected %b", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic bits(input logic [7:0] w, input int from, input int to, input string tag);
    for (int i = from; i <= to; i++) begin
      check($sformatf("%s%0d", tag, i), obs8(), {3'b001, w[7-i]});
      step();
    end
  endtask
  initial begin
    step();
    step();
    check("reset_w8", obs8(), 4'b1000);
    check("reset_w2", obs2(), 4'b1000);
    reset = 1'b0;
    en = 1'b1;
    din2 = 2'b10;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check("w2_bit1", obs2(), 4'b0011);
    step();
    check("w2_bit0", obs2(), 4'b0010);
    step();
    check("w2_done", obs2(), 4'b0100);
    step();
    check("w2_ready", obs2(), 4'b1000);
    din = 8'hA5;
    start = 1'b1;
    step();
    start = 1'b0;
    bits(8'hA5, 0, 7, "a5_bit");
    check("a5_done", obs8(), 4'b0100);
    step();
    check("a5_ready", obs8(), 4'b1000);
    din = 8'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    bits(8'hF0, 0, 0, "f0_bit");
    check("f0_bit1", obs8(), 4'b0011);
    en = 1'b0;
    repeat (3) begin
      step();
      check("f0_hold", obs8(), 4'b0011);
    end
    en = 1'b1;
    step();
    bits(8'hF0, 2, 7, "f0_bit");
    check("f0_done", obs8(), 4'b0100);
    en = 1'b0;
    repeat (2) begin
      step();
      check("done_hold", obs8(), 4'b0100);
    end
    en = 1'b1;
    step();
    check("f0_ready", obs8(), 4'b1000);
    din = 8'h3C;
    start = 1'b1;
    step();
    bits(8'h3C, 0, 2, "3c_bit");
    din = 8'hFF;
    bits(8'h3C, 3, 7, "3c_bit");
    check("3c_done", obs8(), 4'b0100);
    step();
    check("3c_ready", obs8(), 4'b1000);
    step();
    check("ff_start", obs8(), 4'b0011);
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    din = 8'h81;
    start = 1'b1;
    step();
    start = 1'b0;
    bits(8'h81, 0, 2, "81_bit");
    check("81_bit4", obs8(), 4'b0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort", obs8(), 4'b1000);
    seen = 1'b0;
    repeat (12) begin
      step();
      if (done) seen = 1'b1;
    end
    check("no_done", {3'b000, seen}, 4'b0000);
    din = 8'h81;
    start = 1'b1;
    step();
    start = 1'b0;
    check("e_bit7", obs8(), 4'b0011);
    en = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_en0", obs8(), 4'b1000);
    en = 1'b1;
    din = 8'hA5;
    start = 1'b1;
    step();
    start = 1'b0;
    check("first_accept", obs8(), 4'b0011);
    step();
    check("first_bit6", obs8(), 4'b0010);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
